// File: rtl/sdm_pkg.sv
// Shared constants, state encoding and saturation helper for the second-order sigma-delta modulator.
// Widths and full-scale defaults live here; the top-level parameters default to these values.
package sdm_pkg;

    localparam int DW  = 16;
    localparam int OSR = 8;
    localparam int IW  = 24;
    localparam int FS  = 32767;

    localparam logic signed [DW-1:0] FS_POS = DW'(FS);
    localparam logic signed [DW-1:0] FS_NEG = DW'(-FS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic signed [IW-1:0] integ_t;

    // Clamp a wide signed value into a w-bit two's-complement range instead of wrapping.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/sigma_delta_modulator_if.sv
// Sample-in / bitstream-out bundle of the sigma-delta modulator.
// The master side is the PCM source and bitstream consumer; the slave side is the modulator.
interface sigma_delta_modulator_if #(
    parameter int DW = sdm_pkg::DW
);

    logic                 valid_in;
    logic                 ready_in;
    logic signed [DW-1:0] din;
    logic                 valid_out;
    logic                 bit_out;
    logic signed [DW-1:0] dout;
    logic                 underrun;

    modport master (
        output valid_in,
        output din,
        input  ready_in,
        input  valid_out,
        input  bit_out,
        input  dout,
        input  underrun
    );

    modport slave (
        input  valid_in,
        input  din,
        output ready_in,
        output valid_out,
        output bit_out,
        output dout,
        output underrun
    );

endinterface

// File: rtl/sdm_loop.sv
// Two cascaded saturating integrators with a sign quantizer: the noise-shaping core of the modulator.
// q is taken from the current i2 so the feedback used in this clock matches the bit emitted for it.
module sdm_loop
    import sdm_pkg::*;
#(
    parameter int DW = sdm_pkg::DW,
    parameter int IW = sdm_pkg::IW,
    parameter int FS = sdm_pkg::FS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clr,
    input  logic signed [DW-1:0] x,
    output logic                 q
);

    logic signed [IW-1:0] i1_q, i1_d;
    logic signed [IW-1:0] i2_q, i2_d;
    logic signed [63:0]   fb;
    logic signed [63:0]   sum1;
    logic signed [63:0]   sum2;

    assign q = ~i2_q[IW-1];

    always_comb begin
        fb   = q ? 64'(FS) : -64'(FS);
        sum1 = 64'(i1_q) + 64'(x) - fb;
        // i2 integrates the pre-update i1
        sum2 = 64'(i2_q) + 64'(i1_q) - fb;
        i1_d = i1_q;
        i2_d = i2_q;
        if (clr) begin
            i1_d = '0;
            i2_d = '0;
        end else if (run) begin
            i1_d = IW'(sat(sum1, IW));
            i2_d = IW'(sat(sum2, IW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q <= '0;
            i2_q <= '0;
        end else begin
            i1_q <= i1_d;
            i2_q <= i2_d;
        end
    end

endmodule

// File: rtl/sigma_delta_modulator.sv
// Second-order 1-bit sigma-delta modulator: holds each PCM sample for OSR clocks behind a
// one-entry pending buffer and emits one +/-FS bit per clock while running.
//
//   state | meaning
//   IDLE  | integrators cleared, no output; accepts a sample (or replays pending) when enabled
//   RUN   | one output bit per clock; frame boundary at phase OSR-1 swaps in the next sample
module sigma_delta_modulator
    import sdm_pkg::*;
#(
    parameter int DW  = sdm_pkg::DW,
    parameter int OSR = sdm_pkg::OSR,
    parameter int IW  = sdm_pkg::IW,
    parameter int FS  = sdm_pkg::FS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    sigma_delta_modulator_if.slave  sif
);

    localparam int PW = (OSR > 2) ? $clog2(OSR) : 1;

    localparam logic signed [DW-1:0] DOUT_POS = DW'(FS);
    localparam logic signed [DW-1:0] DOUT_NEG = DW'(-FS);
    localparam logic signed [DW-1:0] DIN_MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [PW-1:0]        PH_LAST  = PW'(OSR - 1);

    state_t               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic signed [DW-1:0] x_cur_q, x_cur_d;
    logic signed [DW-1:0] pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic                 bit_q, bit_d;
    logic signed [DW-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 under_q, under_d;

    logic                 ready;
    logic                 accept;
    logic signed [DW-1:0] din_c;
    logic                 loop_run;
    logic                 loop_clr;
    logic                 q;

    // The most negative code has no positive mirror in the feedback, so fold it onto -FS.
    assign din_c  = (sif.din == DIN_MIN) ? (DIN_MIN + DW'(1)) : sif.din;
    assign ready  = !rst && ((state_q == IDLE) ? enable : !pend_full_q);
    assign accept = sif.valid_in && ready;

    sdm_loop #(
        .DW (DW),
        .IW (IW),
        .FS (FS)
    ) u_loop (
        .clk (clk),
        .rst (rst),
        .run (loop_run),
        .clr (loop_clr),
        .x   (x_cur_q),
        .q   (q)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        x_cur_d     = x_cur_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        bit_d       = bit_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        under_d     = 1'b0;
        loop_run    = 1'b0;
        loop_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (enable && pend_full_q) begin
                    // a sample stranded by a stop is replayed first; a concurrent accept queues behind it
                    x_cur_d     = pend_q;
                    pend_full_d = accept;
                    if (accept) begin
                        pend_d = din_c;
                    end
                    phase_d  = '0;
                    loop_clr = 1'b1;
                    state_d  = RUN;
                end else if (accept) begin
                    x_cur_d  = din_c;
                    phase_d  = '0;
                    loop_clr = 1'b1;
                    state_d  = RUN;
                end
            end

            RUN: begin
                loop_run = 1'b1;
                bit_d    = q;
                dout_d   = q ? DOUT_POS : DOUT_NEG;
                valid_d  = 1'b1;
                phase_d  = phase_q + 1'b1;
                if (accept) begin
                    pend_d      = din_c;
                    pend_full_d = 1'b1;
                end
                if (phase_q == PH_LAST) begin
                    if (!enable) begin
                        loop_clr = 1'b1;
                        state_d  = IDLE;
                    end else if (pend_full_q) begin
                        x_cur_d     = pend_q;
                        pend_full_d = accept;
                    end else begin
                        under_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            x_cur_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            bit_q       <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            x_cur_q     <= x_cur_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            bit_q       <= bit_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            under_q     <= under_d;
        end
    end

    assign sif.ready_in  = ready;
    assign sif.valid_out = valid_q;
    assign sif.bit_out   = bit_q;
    assign sif.dout      = dout_q;
    assign sif.underrun  = under_q;

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// Scoreboarded bench: a frame-level model of the modulator loop queues expected bits, compared as they emerge.
module tb_sigma_delta_modulator;
    import sdm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    sigma_delta_modulator_if #(.DW(16)) sif ();

    sigma_delta_modulator dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .sif    (sif)
    );

    always #5 clk = ~clk;

    int     vec_cnt = 0;
    int     err_cnt = 0;
    bit     exp_q[$];
    int     acc_q[$];
    longint m_i1;
    longint m_i2;

    always @(negedge clk) begin
        if (!rst && sif.valid_in && sif.ready_in) acc_q.push_back(int'(sif.din));
    end

    function automatic longint msat(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic int clampx(input int x);
        return (x == -32768) ? -32767 : x;
    endfunction

    function automatic void model_reset();
        m_i1 = 0;
        m_i2 = 0;
    endfunction

    function automatic void model_frame(input int x);
        bit     qb;
        longint fb, n1, n2;
        for (int k = 0; k < 8; k++) begin
            qb = (m_i2 >= 0);
            fb = qb ? 64'sd32767 : -64'sd32767;
            n1 = msat(m_i1 + longint'(x) - fb);
            n2 = msat(m_i2 + m_i1 - fb);
            m_i1 = n1;
            m_i2 = n2;
            exp_q.push_back(qb);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        sif.valid_in = 1'b0;
        sif.din = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = 16'sd5;
        tick();
        tick();
        vec_cnt++; if (sif.ready_in !== 1'b0) begin err_cnt++; $display("FAIL reset_ready_in got=%0b want=0", sif.ready_in); end
        vec_cnt++; if (sif.valid_out !== 1'b0) begin err_cnt++; $display("FAIL reset_valid_out got=%0b want=0", sif.valid_out); end
        vec_cnt++; if (sif.bit_out !== 1'b0) begin err_cnt++; $display("FAIL reset_bit_out got=%0b want=0", sif.bit_out); end
        vec_cnt++; if (sif.dout !== 16'sd0) begin err_cnt++; $display("FAIL reset_dout got=%0d want=0", sif.dout); end
        vec_cnt++; if (sif.underrun !== 1'b0) begin err_cnt++; $display("FAIL reset_underrun got=%0b want=0", sif.underrun); end
        do_reset();
    endtask

    task automatic test_zero();
        int n, ones, acc0;
        bit e;
        do_reset();
        acc0 = acc_q.size();
        for (int f = 0; f < 8; f++) model_frame(0);
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = '0;
        n = 0;
        ones = 0;
        for (int c = 0; c < 200 && n < 64; c++) begin
            tick();
            if (sif.valid_out === 1'b1) begin
                e = exp_q.pop_front();
                if (n == 0) begin
                    vec_cnt++; if (sif.bit_out !== 1'b1) begin err_cnt++; $display("FAIL zero_first_bit got=%0b want=1", sif.bit_out); end
                end
                vec_cnt++; if (sif.bit_out !== e) begin err_cnt++; $display("FAIL zero_bit[%0d] got=%0b want=%0b", n, sif.bit_out, e); end
                vec_cnt++; if (sif.dout !== (e ? FS_POS : FS_NEG)) begin err_cnt++; $display("FAIL zero_dout[%0d] got=%0d want=%0d", n, sif.dout, e ? FS_POS : FS_NEG); end
                ones += sif.bit_out ? 1 : 0;
                n++;
            end
        end
        vec_cnt++; if (n != 64) begin err_cnt++; $display("FAIL zero_timeout bits=%0d want=64", n); end
        vec_cnt++; if (ones < 30 || ones > 34) begin err_cnt++; $display("FAIL zero_ones got=%0d want=32+-2", ones); end
        vec_cnt++; if (acc_q.size() - acc0 != 9) begin err_cnt++; $display("FAIL zero_accepts got=%0d want=9", acc_q.size() - acc0); end
    endtask

    task automatic test_dc(input int x, input int nbits, input int lo, input int hi);
        int n, ones;
        bit e;
        do_reset();
        for (int f = 0; f < nbits / 8; f++) model_frame(clampx(x));
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = 16'(x);
        n = 0;
        ones = 0;
        for (int c = 0; c < nbits + 50 && n < nbits; c++) begin
            tick();
            if (sif.valid_out === 1'b1) begin
                e = exp_q.pop_front();
                vec_cnt++; if (sif.bit_out !== e) begin err_cnt++; $display("FAIL dc%0d_bit[%0d] got=%0b want=%0b", x, n, sif.bit_out, e); end
                ones += sif.bit_out ? 1 : 0;
                n++;
            end
        end
        vec_cnt++; if (n != nbits) begin err_cnt++; $display("FAIL dc%0d_timeout bits=%0d want=%0d", x, n, nbits); end
        vec_cnt++; if (ones < lo || ones > hi) begin err_cnt++; $display("FAIL dc%0d_ones got=%0d want=[%0d,%0d]", x, ones, lo, hi); end
        vec_cnt++; if (longint'(dut.u_loop.i1_q) != m_i1) begin err_cnt++; $display("FAIL dc%0d_i1 got=%0d want=%0d", x, dut.u_loop.i1_q, m_i1); end
        vec_cnt++; if (longint'(dut.u_loop.i2_q) != m_i2) begin err_cnt++; $display("FAIL dc%0d_i2 got=%0d want=%0d", x, dut.u_loop.i2_q, m_i2); end
    endtask

    task automatic test_underrun();
        int acc0;
        bit e;
        do_reset();
        acc0 = acc_q.size();
        for (int f = 0; f < 4; f++) model_frame(12000);
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = 16'sd12000;
        tick();
        sif.valid_in = 1'b0;
        for (int n = 0; n < 32; n++) begin
            tick();
            e = exp_q.pop_front();
            vec_cnt++; if (sif.valid_out !== 1'b1) begin err_cnt++; $display("FAIL under_valid[%0d] got=%0b want=1", n, sif.valid_out); end
            vec_cnt++; if (sif.bit_out !== e) begin err_cnt++; $display("FAIL under_bit[%0d] got=%0b want=%0b", n, sif.bit_out, e); end
            vec_cnt++; if (sif.underrun !== ((n % 8) == 7)) begin err_cnt++; $display("FAIL under_pulse[%0d] got=%0b want=%0b", n, sif.underrun, (n % 8) == 7); end
        end
        vec_cnt++; if (acc_q.size() - acc0 != 1) begin err_cnt++; $display("FAIL under_accepts got=%0d want=1", acc_q.size() - acc0); end
    endtask

    task automatic test_back_to_back();
        int n, k, acc0, ready_hi;
        bit e;
        do_reset();
        acc0 = acc_q.size();
        for (int j = 0; j < 8; j++) model_frame(-16000 + 4000 * j);
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = 16'(-16000);
        n = 0;
        k = 0;
        ready_hi = 0;
        for (int c = 0; c < 200 && n < 64; c++) begin
            tick();
            if (acc_q.size() - acc0 > k) begin
                k = acc_q.size() - acc0;
                sif.din = 16'(-16000 + 4000 * k);
            end
            if (sif.valid_out === 1'b1) begin
                e = exp_q.pop_front();
                vec_cnt++; if (sif.bit_out !== e) begin err_cnt++; $display("FAIL b2b_bit[%0d] got=%0b want=%0b", n, sif.bit_out, e); end
                if (sif.ready_in === 1'b1) ready_hi++;
                n++;
            end
        end
        vec_cnt++; if (n != 64) begin err_cnt++; $display("FAIL b2b_timeout bits=%0d want=64", n); end
        vec_cnt++; if (ready_hi != 8) begin err_cnt++; $display("FAIL b2b_ready_cycles got=%0d want=8", ready_hi); end
        vec_cnt++; if (acc_q.size() - acc0 != 9) begin err_cnt++; $display("FAIL b2b_accepts got=%0d want=9", acc_q.size() - acc0); end
        for (int i = 0; i < 9 && acc0 + i < acc_q.size(); i++) begin
            vec_cnt++; if (acc_q[acc0 + i] != -16000 + 4000 * i) begin err_cnt++; $display("FAIL b2b_order[%0d] got=%0d want=%0d", i, acc_q[acc0 + i], -16000 + 4000 * i); end
        end
    endtask

    task automatic test_enable_drop();
        int acc0;
        bit e;
        do_reset();
        acc0 = acc_q.size();
        model_frame(8000);
        model_reset();
        model_frame(-12000);
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = 16'sd8000;
        tick();
        sif.din = -16'sd12000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) sif.valid_in = 1'b0;
            if (c == 3) enable = 1'b0;
            e = exp_q.pop_front();
            vec_cnt++; if (sif.valid_out !== 1'b1) begin err_cnt++; $display("FAIL drop_valid[%0d] got=%0b want=1", c, sif.valid_out); end
            vec_cnt++; if (sif.bit_out !== e) begin err_cnt++; $display("FAIL drop_bit[%0d] got=%0b want=%0b", c, sif.bit_out, e); end
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            vec_cnt++; if (sif.valid_out !== 1'b0) begin err_cnt++; $display("FAIL drop_idle_valid[%0d] got=%0b want=0", c, sif.valid_out); end
        end
        enable = 1'b1;
        tick();
        vec_cnt++; if (sif.valid_out !== 1'b0) begin err_cnt++; $display("FAIL drop_restart_valid got=%0b want=0", sif.valid_out); end
        for (int c = 0; c < 8; c++) begin
            tick();
            e = exp_q.pop_front();
            vec_cnt++; if (sif.valid_out !== 1'b1) begin err_cnt++; $display("FAIL replay_valid[%0d] got=%0b want=1", c, sif.valid_out); end
            vec_cnt++; if (sif.bit_out !== e) begin err_cnt++; $display("FAIL replay_bit[%0d] got=%0b want=%0b", c, sif.bit_out, e); end
            vec_cnt++; if (sif.underrun !== (c == 7)) begin err_cnt++; $display("FAIL replay_underrun[%0d] got=%0b want=%0b", c, sif.underrun, c == 7); end
        end
        vec_cnt++; if (acc_q.size() - acc0 != 2) begin err_cnt++; $display("FAIL drop_accepts got=%0d want=2", acc_q.size() - acc0); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = 16'sd5000;
        for (int c = 0; c < 12; c++) tick();
        rst = 1'b1;
        tick();
        vec_cnt++; if (sif.valid_out !== 1'b0) begin err_cnt++; $display("FAIL midrst_valid got=%0b want=0", sif.valid_out); end
        vec_cnt++; if (sif.bit_out !== 1'b0) begin err_cnt++; $display("FAIL midrst_bit got=%0b want=0", sif.bit_out); end
        vec_cnt++; if (sif.dout !== 16'sd0) begin err_cnt++; $display("FAIL midrst_dout got=%0d want=0", sif.dout); end
        vec_cnt++; if (sif.underrun !== 1'b0) begin err_cnt++; $display("FAIL midrst_underrun got=%0b want=0", sif.underrun); end
        vec_cnt++; if (sif.ready_in !== 1'b0) begin err_cnt++; $display("FAIL midrst_ready got=%0b want=0", sif.ready_in); end
        vec_cnt++; if (dut.state_q !== IDLE) begin err_cnt++; $display("FAIL midrst_state got=%0d want=IDLE", dut.state_q); end
        rst = 1'b0;
        sif.valid_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vec_cnt++; if (sif.valid_out !== 1'b0) begin err_cnt++; $display("FAIL midrst_no_replay[%0d] got=%0b want=0", c, sif.valid_out); end
        end
    endtask

    task automatic test_cic_chain();
        longint integ[4];
        longint dly[4];
        longint v, prev, sum, avg, want;
        int n, outs;
        do_reset();
        for (int s = 0; s < 4; s++) begin integ[s] = 0; dly[s] = 0; end
        enable = 1'b1;
        sif.valid_in = 1'b1;
        sif.din = 16'sd16384;
        n = 0;
        outs = 0;
        sum = 0;
        for (int c = 0; c < 400 && n < 320; c++) begin
            tick();
            if (sif.valid_out === 1'b1) begin
                integ[0] += longint'(sif.dout);
                for (int s = 1; s < 4; s++) integ[s] += integ[s-1];
                if ((n % 8) == 7) begin
                    v = integ[3];
                    for (int s = 0; s < 4; s++) begin
                        prev = dly[s];
                        dly[s] = v;
                        v = v - prev;
                    end
                    if (outs >= 8) sum += v;
                    outs++;
                end
                n++;
            end
        end
        vec_cnt++; if (n != 320) begin err_cnt++; $display("FAIL cic_timeout bits=%0d want=320", n); end
        avg = sum / 32;
        want = 64'd4096 * 64'd16384;
        vec_cnt++; if (avg < want - want * 8 / 100 || avg > want + want * 8 / 100) begin err_cnt++; $display("FAIL cic_dc got=%0d want=%0d+-8pct", avg, want); end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        sif.valid_in = 1'b0;
        sif.din = '0;
        test_reset();
        test_zero();
        test_dc(16384, 256, 188, 196);
        test_dc(-16384, 256, 60, 68);
        test_dc(-32768, 320, 0, 4);
        test_underrun();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_run();
        test_cic_chain();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sigma_delta_modulator.md
Name: sigma_delta_modulator

Overview:
- Second-order 1-bit sigma-delta modulator; the transmit-side counterpart of the CIC decimation + FIR chain.
- Accepts 16-bit PCM samples through a valid/ready handshake and holds each sample for OSR clocks.
- Emits one ±1 bit per clock, both as a raw bit and as ±32767 fixed-point. The fixed-point output feeds cic_decimation_filter (N=OSR) directly.

Parameters:
- DW, 16, input/output sample width.
- OSR, 8, output bits per input sample; power of two, ≥2.
- IW, 24, signed integrator width.
- FS, 32767, feedback magnitude and output full-scale value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run request; stop takes effect at a frame boundary
- valid_in  in  1  din valid
- ready_in  out  1  block can accept din this cycle
- din  in  DW  signed PCM sample
- valid_out  out  1  bit_out/dout valid
- bit_out  out  1  modulator bit, 1 = +FS
- dout  out  DW  signed +FS / -FS copy of bit_out
- underrun  out  1  one-cycle pulse: frame boundary reached with no pending sample

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, i1=i2=0, phase=0, x_cur=0, pending empty; ready_in=0, valid_out=0, bit_out=0, dout=0, underrun=0. Reset mid-RUN aborts immediately and loses the pending sample.
- Input clamp: din=-32768 is treated as -32767.
- States: IDLE and RUN.
- IDLE behaviour:
  - ready_in=enable.
  - On valid_in&ready_in: x_cur<=din; i1,i2,phase<=0; go to RUN.
  - Otherwise hold; valid_out=0.
- RUN, every clock edge:
  - q = (i2 >= 0); fb = q ? +FS : -FS.
  - i1 <= sat(i1 + x_cur - fb).
  - i2 <= sat(i2 + i1 - fb), using the old i1.
  - sat clamps to [-(2^(IW-1)), 2^(IW-1)-1] and never wraps.
  - bit_out<=q; dout<=q ? FS : -FS; valid_out<=1.
  - phase<=phase+1, wrapping mod OSR.
- Pending buffer (one entry):
  - In RUN, ready_in = !pending_full.
  - An accept writes pending.
- Frame boundary (RUN and phase==OSR-1):
  - If enable=0: go to IDLE; i1,i2 cleared; valid_out<=0 next cycle; pending retained.
  - Else if pending_full: x_cur<=pending; pending cleared. An accept in the same cycle refills pending (ready_in is 0 here if pending was full).
  - Else: x_cur held (repeat last sample); underrun pulses 1 cycle.
- Latency:
  - Accept at edge t → first valid_out=1 after edge t+1.
  - Steady state: exactly one accept per OSR cycles.
- valid_out is continuous (1 every cycle) while RUN, matching the decimator's expectation.

Decomposition:
- Package sdm_pkg holds:
  - FS_POS / FS_NEG constants.
  - State enum {IDLE, RUN}.
  - Integrator type logic signed [IW-1:0].
  - A sat() function.
- Sub-module sdm_loop:
  - Integrator pair, quantizer and saturation.
  - Ports: clk, rst, run, clr, x (DW), q (1).
- The top level owns the handshake, pending buffer, phase counter and FSM.

Test Plan:
1. Zero input: din=0 held valid, enable=1, 64 output bits → first bit_out=1; ones count 32±2; dout only ±32767; ready_in accepts once per 8 cycles.
2. DC levels over 256 bits:
   - din=+16384 → ones 192±4.
   - din=-16384 → ones 64±4.
   - din=-32768 → ones ≤4, i1/i2 never wrap (assert within IW range).
3. Underrun: one sample then valid_in=0 → underrun pulses at each phase==7 boundary (every 8 cycles); x_cur stays the first sample; valid_out stays 1.
4. Backpressure: valid_in held 1 with a counting din → pending fills, ready_in low except one cycle per frame; every accepted value consumed in order; none dropped or duplicated.
5. Enable drop mid-frame at phase 3 → RUN continues to phase 7; valid_out=0 from the following cycle; the pending sample is replayed on the next enable with integrators reset.
6. rst asserted mid-RUN → next cycle all outputs 0, state IDLE; chain into cic_decimation_filter(N=8,STAGES=4) with din=+16384 → CIC output settles near its DC gain × 0.5 FS.
